dds_fm_sweep: RTL

Parametrised successor to the single-accumulator FM DDS: a phase-accumulator NCO with configurable phase width and a truncated phase output. Adds registered frequency control (immediate or phase-continuous load at wrap), a linear frequency-sweep (chirp) engine with its own state machine, clock enable, synchronous phase clear and a wrap pulse. It sits ahead of the TX modulator/DAC path and drives either the square carrier or a downstream phase-to-amplitude stage.

---
 rtl/dds_fm_sweep.sv | 115 +++++++++++
 1 files changed

// File: rtl/dds_fm_sweep.sv
// Phase-accumulator NCO with registered frequency control, optional wrap-synchronous
// frequency load and a linear chirp engine.
module dds_fm_sweep #(
   parameter int unsigned PHASE_W   = 32,
   parameter int unsigned OUT_W     = 12,
   parameter int unsigned CNT_W     = 16,
   parameter bit          SYNC_LOAD = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] faza_f0,
   input  logic               f0_ld,
   input  logic [PHASE_W-1:0] faza_m,
   input  logic [PHASE_W-1:0] sweep_step,
   input  logic [CNT_W-1:0]   sweep_len,
   input  logic               sweep_start,
   input  logic               sweep_stop,
   input  logic               ph_clr,
   output logic               fout,
   output logic [OUT_W-1:0]   phase,
   output logic               wrap,
   output logic               sweep_busy,
   output logic               sweep_done
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state;
   logic [PHASE_W-1:0] accum;
   logic [PHASE_W-1:0] f_cur;
   logic [PHASE_W-1:0] shadow;
   logic               pending;
   logic [CNT_W-1:0]   cnt;
   logic [PHASE_W-1:0] inc;
   logic [PHASE_W:0]   sum;
   logic               carry;
   logic               wrap_load;

   assign inc   = f_cur + faza_m;
   assign sum   = {1'b0, accum} + {1'b0, inc};
   assign carry = sum[PHASE_W];
   // Only a real accumulator wrap may release a pending load; a cleared edge does not count.
   assign wrap_load = en & ~ph_clr & carry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         accum <= '0;
         wrap  <= 1'b0;
      end else if (ph_clr) begin
         accum <= '0;
         wrap  <= 1'b0;
      end else if (en) begin
         accum <= sum[PHASE_W-1:0];
         wrap  <= carry;
      end else begin
         wrap  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         f_cur      <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         cnt        <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (sweep_start && !sweep_stop) begin
                  f_cur   <= faza_f0;
                  cnt     <= sweep_len;
                  pending <= 1'b0;
                  if (sweep_len == '0)
                     sweep_done <= 1'b1;
                  else
                     state <= SWEEP;
               end else if (SYNC_LOAD) begin
                  if (pending && wrap_load) begin
                     f_cur   <= shadow;
                     pending <= 1'b0;
                  end
                  if (f0_ld) begin
                     shadow  <= faza_f0;
                     pending <= 1'b1;
                  end
               end else if (f0_ld) begin
                  f_cur <= faza_f0;
               end
            end
            SWEEP: begin
               if (sweep_stop) begin
                  state <= IDLE;
               end else if (en) begin
                  f_cur <= f_cur + sweep_step;
                  cnt   <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state      <= IDLE;
                     sweep_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fout       = accum[PHASE_W-1];
   assign phase      = accum[PHASE_W-1 -: OUT_W];
   assign sweep_busy = (state == SWEEP);

endmodule
